seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle barrel shifter that sequences one shift stage per clock: 16, 8, 4, 2, then 1.
- Sits between the ALU operand registers and the ALU result mux. It replaces the purely combinational 5-stage shift chain with a registered, handshaked unit.
- Supports logical left shift (SLL) and arithmetic right shift (SRA) of a 32-bit operand by a 5-bit amount.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH) and sets the stage count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request to start an operation.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- data_operand  input  WIDTH  value to shift.
- ctrl_shiftamt  input  SHAMT_W  shift amount, 0..31.
- ctrl_op  input  1  0 = SLL, 1 = SRA.
- out_valid  output  1  data_result holds a completed result.
- out_ready  input  1  consumer accepts the result.
- data_result  output  WIDTH  shifted result; registered.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, working register = 0, data_result = 0, out_valid = 0, busy = 0, stage index = SHAMT_W-1. in_ready = 1 because it is decoded from IDLE.
- States and transitions:
  - IDLE: on in_valid & in_ready, capture data_operand, ctrl_shiftamt and ctrl_op; set stage index = 4; go to SHIFT.
  - SHIFT: each edge applies stage 2^idx to the working register if shamt[idx] = 1, otherwise passes it through; idx decrements. The edge that applies idx = 0 goes to DONE.
  - DONE: out_valid = 1 and data_result = working register. On out_ready, clear out_valid and go to IDLE.
- Fill rules: SLL fills with zeros from the LSB. SRA replicates the operand sign bit (captured operand[31]) into every vacated MSB at every stage.
- Latency: fixed and independent of shamt. out_valid rises at the 5th rising edge after the accepting edge. shamt = 0 still takes 5 cycles and returns the operand unchanged.
- Throughput: at most one operation per 7 cycles. in_ready is low from the accept edge until the edge after the result handshake.
- Inputs are sampled only on the accept edge. Changes to data_operand, ctrl_* or in_valid while busy are ignored; nothing is queued.
- data_result and out_valid stay stable while out_valid = 1 and out_ready = 0. Backpressure may last indefinitely.
- out_ready while not in DONE has no effect.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately and drops the result; all outputs take their reset values.
- No X propagation: the working register is always loaded, never left unassigned.

Decomposition:
- Package seq_shift_pkg holds:
  - op encodings SHIFT_OP_SLL = 1'b0 and SHIFT_OP_SRA = 1'b1;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE;
  - NUM_STAGES = 5.
- Sub-module shift_stage_sel: combinational. Inputs are the working value, stage index, enable bit and op; output is the value shifted by 2^idx with the correct fill. The top level holds the FSM, the counter and the registers.

Test Plan:
- SRA, operand 0x80000000, shamt 31 -> data_result 0xFFFFFFFF; out_valid high exactly 5 edges after accept.
- SLL, operand 0x00000001, shamt 31 -> 0x80000000. SLL, operand 0xFFFFFFFF, shamt 4 -> 0xFFFFFFF0.
- shamt 0, operand 0x12345678, either op -> 0x12345678 with the same 5-cycle latency.
- SRA, operand 0x7FFF0000, shamt 18, out_ready held low 3 cycles -> 0x00001FFF held stable. in_valid pulsed while busy is not accepted. After the handshake, in_ready returns high and the next op is accepted.
- Operand and ctrl inputs changed every cycle after accept -> result matches the values captured at the accept edge.
- reset driven low in the 3rd SHIFT cycle -> out_valid = 0 and data_result = 0 without waiting for a clock edge; after release, in_ready = 1 and a fresh op completes correctly.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// rtl/seq_shift_pkg.sv - shared encodings for the sequential shift unit
package seq_shift_pkg;

    // Operation select
    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One stage per shift-amount bit: 16, 8, 4, 2, 1
    localparam int NUM_STAGES = 5;

endpackage

// File: rtl/seq_shift_unit_if.sv
// rtl/seq_shift_unit_if.sv - request/result handshake bundle for seq_shift_unit
//
// Signals:
//   in_valid/in_ready                       request handshake
//   data_operand, ctrl_shiftamt, ctrl_op    request payload
//   out_valid/out_ready                     result handshake
//   data_result                             registered result
//   busy                                    unit is in SHIFT or DONE
// Modports: master drives requests and consumes results; slave is the unit.
interface seq_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operand;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic               ctrl_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic               busy;

    modport master (
        output in_valid, data_operand, ctrl_shiftamt, ctrl_op, out_ready,
        input  in_ready, out_valid, data_result, busy
    );

    modport slave (
        input  in_valid, data_operand, ctrl_shiftamt, ctrl_op, out_ready,
        output in_ready, out_valid, data_result, busy
    );
endinterface

// File: rtl/shift_stage_sel.sv
// rtl/shift_stage_sel.sv - one combinational barrel-shift stage (shift by 2^idx)
//
// Ports:
//   i_value  working value entering the stage
//   i_idx    stage index; shift distance is 2^i_idx
//   i_en     shift-amount bit for this stage; 0 passes the value through
//   i_op     SHIFT_OP_SLL or SHIFT_OP_SRA
//   i_sign   sign bit captured from the original operand (SRA fill)
//   o_value  stage result
module shift_stage_sel
    import seq_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   i_value,
    input  logic [SHAMT_W-1:0] i_idx,
    input  logic               i_en,
    input  logic               i_op,
    input  logic               i_sign,
    output logic [WIDTH-1:0]   o_value
);

    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0]   w_fill_mask;

    assign w_amt       = SHAMT_W'(1) << i_idx;
    // Ones in the MSB positions vacated by a right shift of w_amt
    assign w_fill_mask = ~({WIDTH{1'b1}} >> w_amt);

    always_comb begin
        o_value = i_value;
        if (i_en) begin
            case (i_op)
                SHIFT_OP_SLL: o_value = i_value << w_amt;
                default:      o_value = (i_value >> w_amt) | (i_sign ? w_fill_mask : '0);
            endcase
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle SLL/SRA barrel shifter, one stage per clock
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    seq_shift_unit_if.slave: request, result and busy signals
//
// Accept in IDLE, walk stages 16,8,4,2,1 in SHIFT (five edges), present
// the registered result in DONE until out_ready, then return to IDLE.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    seq_shift_unit_if.slave  bus
);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_op;
    logic               r_sign;
    logic [SHAMT_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;

    logic               w_accept;
    logic [WIDTH-1:0]   w_stage_out;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    shift_stage_sel #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .i_value (r_work),
        .i_idx   (r_idx),
        .i_en    (r_shamt[r_idx]),
        .i_op    (r_op),
        .i_sign  (r_sign),
        .o_value (w_stage_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_shamt     <= '0;
            r_op        <= SHIFT_OP_SLL;
            r_sign      <= 1'b0;
            r_idx       <= SHAMT_W'(NUM_STAGES - 1);
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= bus.data_operand;
                        r_shamt <= bus.ctrl_shiftamt;
                        r_op    <= bus.ctrl_op;
                        r_sign  <= bus.data_operand[WIDTH-1];
                        r_idx   <= SHAMT_W'(NUM_STAGES - 1);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_stage_out;
                    if (r_idx == '0) begin
                        // Last stage: result goes straight into the output register
                        r_result    <= w_stage_out;
                        r_out_valid <= 1'b1;
                        r_idx       <= SHAMT_W'(NUM_STAGES - 1);
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - SHAMT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.data_result = r_result;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - scoreboard bench for seq_shift_unit
module tb_seq_shift_unit;
    import seq_shift_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    seq_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic op);
        logic [31:0] r;
        if (op == SHIFT_OP_SRA) r = $signed(a) >>> sh;
        else                    r = a << sh;
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic op,
                          input int hold, input bit scramble, input bit poke, input string tag);
        int          lat;
        logic [31:0] exp;
        sb_q.push_back(model(a, sh, op));
        @(negedge clock);
        check_val({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid      = 1'b1;
        bus.data_operand  = a;
        bus.ctrl_shiftamt = sh;
        bus.ctrl_op       = op;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.out_valid) break;
            if (lat == 1) begin
                check_val({tag, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
                check_val({tag, "/busy"}, 32'(bus.busy), 32'd1);
            end
            if (scramble) begin
                bus.data_operand  = $urandom;
                bus.ctrl_shiftamt = 5'($urandom);
                bus.ctrl_op       = 1'($urandom);
            end
            if (poke) bus.in_valid = ~bus.in_valid;
        end
        bus.in_valid = 1'b0;
        check_val({tag, "/latency"}, 32'(lat), 32'd5);
        exp = sb_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check_val({tag, "/held_valid"}, 32'(bus.out_valid), 32'd1);
            check_val({tag, "/held_data"}, bus.data_result, exp);
            @(negedge clock);
        end
        check_val({tag, "/result"}, bus.data_result, exp);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        check_val({tag, "/valid_cleared"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "/in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.data_operand  = '0;
        bus.ctrl_shiftamt = '0;
        bus.ctrl_op       = SHIFT_OP_SLL;
        bus.out_ready     = 1'b0;
        #12;
        check_val("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst/data_result", bus.data_result, 32'd0);
        check_val("rst/busy", 32'(bus.busy), 32'd0);
        check_val("rst/in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        run_op(32'h8000_0000, 5'd31, SHIFT_OP_SRA, 0, 1'b0, 1'b0, "sra_min_31");
        run_op(32'h0000_0001, 5'd31, SHIFT_OP_SLL, 0, 1'b0, 1'b0, "sll_1_31");
        run_op(32'hFFFF_FFFF, 5'd4,  SHIFT_OP_SLL, 0, 1'b0, 1'b0, "sll_ones_4");
        run_op(32'h1234_5678, 5'd0,  SHIFT_OP_SLL, 0, 1'b0, 1'b0, "sll_zero");
        run_op(32'h1234_5678, 5'd0,  SHIFT_OP_SRA, 0, 1'b0, 1'b0, "sra_zero");
        run_op(32'h7FFF_0000, 5'd18, SHIFT_OP_SRA, 3, 1'b0, 1'b1, "sra_hold");
        run_op(32'hA5A5_1234, 5'd7,  SHIFT_OP_SLL, 1, 1'b1, 1'b0, "scramble_sll");
        run_op(32'hC000_1234, 5'd9,  SHIFT_OP_SRA, 0, 1'b1, 1'b1, "scramble_sra");

        // Abort in the third SHIFT cycle; the previous result must be dropped
        @(negedge clock);
        bus.in_valid      = 1'b1;
        bus.data_operand  = 32'hDEAD_BEEF;
        bus.ctrl_shiftamt = 5'd3;
        bus.ctrl_op       = SHIFT_OP_SRA;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_val("abort/out_valid", 32'(bus.out_valid), 32'd0);
        check_val("abort/data_result", bus.data_result, 32'd0);
        check_val("abort/busy", 32'(bus.busy), 32'd0);
        check_val("abort/in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        run_op(32'h0F0F_0F0F, 5'd12, SHIFT_OP_SLL, 0, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 6; i++) begin
            run_op($urandom, 5'($urandom), 1'($urandom), i % 3, 1'b1, 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
